// File: rtl/rv32i_pkg.sv
// rv32i_pkg: instruction formats, opcodes and encoder error codes shared with the decoder.
package rv32i_pkg;
   typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_MISALIGN = 2'd1;
   localparam logic [1:0] ERR_RANGE    = 2'd2;
   localparam logic [1:0] ERR_FMT      = 2'd3;
   function automatic logic in_range(input logic signed [31:0] v, input int lo, input int hi);
      return v >= lo && v <= hi;
   endfunction
endpackage

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request handshake plus IMEM write port of the instruction encoder.
interface instr_encoder_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_fmt;
   logic [6:0]  req_opcode;
   logic [2:0]  req_funct3;
   logic [6:0]  req_funct7;
   logic [4:0]  req_rd;
   logic [4:0]  req_rs1;
   logic [4:0]  req_rs2;
   logic [31:0] req_imm;
   logic        req_last;
   logic        imem_wr_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_wr_data;
   logic        imem_wr_ack;
   modport master (
      output req_valid, req_fmt, req_opcode, req_funct3, req_funct7, req_rd, req_rs1, req_rs2,
             req_imm, req_last, imem_wr_ack,
      input  req_ready, imem_wr_en, imem_addr, imem_wr_data
   );
   modport slave (
      input  req_valid, req_fmt, req_opcode, req_funct3, req_funct7, req_rd, req_rs1, req_rs2,
             req_imm, req_last, imem_wr_ack,
      output req_ready, imem_wr_en, imem_addr, imem_wr_data
   );
endinterface

// File: rtl/instr_pack.sv
// instr_pack: packs RV32I instruction fields into a word and range-checks the immediate.
module instr_pack
   import rv32i_pkg::*;
(
   input  logic [2:0]  fmt,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [6:0]  funct7,
   input  logic [4:0]  rd,
   input  logic [4:0]  rs1,
   input  logic [4:0]  rs2,
   input  logic [31:0] imm,
   output logic [31:0] word,
   output logic [1:0]  code
);
   logic shift;
   // SLLI/SRLI/SRAI carry funct7 in place of imm[11:5]
   assign shift = opcode == OP_IMM && funct3[1:0] == 2'b01;
   always_comb begin
      word = '0;
      code = ERR_NONE;
      case (fmt)
         FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
         FMT_I: begin
            word = shift ? {funct7, imm[4:0], rs1, funct3, rd, opcode} : {imm[11:0], rs1, funct3, rd, opcode};
            code = (shift ? in_range(imm, 0, 31) : in_range(imm, -2048, 2047)) ? ERR_NONE : ERR_RANGE;
         end
         FMT_S: begin
            word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            code = in_range(imm, -2048, 2047) ? ERR_NONE : ERR_RANGE;
         end
         FMT_B: begin
            word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            code = imm[0] ? ERR_MISALIGN : in_range(imm, -4096, 4094) ? ERR_NONE : ERR_RANGE;
         end
         FMT_U: begin
            word = {imm[31:12], rd, opcode};
            code = |imm[11:0] ? ERR_MISALIGN : ERR_NONE;
         end
         FMT_J: begin
            word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            code = imm[0] ? ERR_MISALIGN : in_range(imm, -1048576, 1048574) ? ERR_NONE : ERR_RANGE;
         end
         default: code = ERR_FMT;
      endcase
   end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts field-level instruction requests and writes the packed words
// to consecutive IMEM addresses until the last instruction or IMEM capacity.
module instr_encoder
   import rv32i_pkg::*;
#(
   parameter int          ADDR_WIDTH = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  restart,
   instr_encoder_if.slave        bus,
   output logic                  done,
   output logic                  full,
   output logic                  err,
   output logic [1:0]            err_code,
   output logic [ADDR_WIDTH:0]   count
);
   typedef enum logic [1:0] {READY, WRITE, ERR, DONE} state_e;
   localparam logic [ADDR_WIDTH:0] CAP = {1'b1, {ADDR_WIDTH{1'b0}}};
   state_e state, state_d;
   logic [31:0] word;
   logic [1:0] code;
   logic last_q;
   logic [ADDR_WIDTH:0] count_inc;
   assign count_inc = count + 1'b1;
   instr_pack u_pack (
      .fmt(bus.req_fmt), .opcode(bus.req_opcode), .funct3(bus.req_funct3), .funct7(bus.req_funct7),
      .rd(bus.req_rd), .rs1(bus.req_rs1), .rs2(bus.req_rs2), .imm(bus.req_imm),
      .word(word), .code(code)
   );
   always_comb begin
      state_d = state;
      case (state)
         READY: if (bus.req_valid) state_d = code == ERR_NONE ? WRITE : ERR;
         WRITE: if (bus.imem_wr_ack) state_d = last_q || count_inc == CAP ? DONE : READY;
         ERR:   state_d = READY;
         DONE:  if (restart) state_d = READY;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= READY;
         bus.imem_addr <= BASE_ADDR;
         bus.imem_wr_data <= '0;
         err_code <= ERR_NONE;
         count <= '0;
         last_q <= 1'b0;
      end else begin
         state <= state_d;
         if (state == READY && bus.req_valid) begin
            err_code <= code;
            last_q <= bus.req_last;
            if (code == ERR_NONE) bus.imem_wr_data <= word;
         end
         if (state == WRITE && bus.imem_wr_ack) begin
            bus.imem_addr <= bus.imem_addr + 32'd4;
            count <= count_inc;
         end
         if (state == DONE && restart) begin
            bus.imem_addr <= BASE_ADDR;
            count <= '0;
         end
      end
   end
   assign bus.req_ready = state == READY;
   assign bus.imem_wr_en = state == WRITE;
   assign done = state == DONE;
   assign err = state == ERR;
   assign full = count == CAP;
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed requests against a transaction-level model of the encoder
// with a 4-entry IMEM so capacity exhaustion is reachable.
module tb_instr_encoder;
   localparam int AW = 2;
   localparam int CAP = 4;
   localparam logic [31:0] BASE = 32'h0;
   logic clk = 1'b0, reset = 1'b1, restart = 1'b0;
   logic done, full, err;
   logic [1:0] err_code;
   logic [AW:0] count;
   instr_encoder_if bus();
   instr_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
      .clk(clk), .reset(reset), .restart(restart), .bus(bus),
      .done(done), .full(full), .err(err), .err_code(err_code), .count(count)
   );
   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   typedef struct { logic [31:0] addr; logic [31:0] data; logic last; } wr_t;
   wr_t q[$];
   int m_count = 0;
   logic m_done = 1'b0, m_err = 1'b0, started = 1'b0;
   logic [1:0] m_code = 2'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected word/code from the field layout expressed as bit positions of each immediate slice
   function automatic void enc(input int f, op, f3, f7, rd, rs1, rs2, imm, output logic [31:0] w, output logic [1:0] c);
      bit sh = f == 1 && op == 'h13 && (f3 == 1 || f3 == 5);
      w = 32'h0;
      c = 2'd0;
      case (f)
         0: w = op | rd << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | f7 << 25;
         1: begin
            if (sh) begin
               w = op | rd << 7 | f3 << 12 | rs1 << 15 | (imm & 31) << 20 | f7 << 25;
               c = (imm < 0 || imm > 31) ? 2'd2 : 2'd0;
            end else begin
               w = op | rd << 7 | f3 << 12 | rs1 << 15 | (imm & 'hfff) << 20;
               c = (imm < -2048 || imm > 2047) ? 2'd2 : 2'd0;
            end
         end
         2: begin
            w = op | (imm & 31) << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | ((imm >> 5) & 127) << 25;
            c = (imm < -2048 || imm > 2047) ? 2'd2 : 2'd0;
         end
         3: begin
            w = op | ((imm >> 11) & 1) << 7 | ((imm >> 1) & 15) << 8 | f3 << 12 | rs1 << 15 | rs2 << 20
                | ((imm >> 5) & 63) << 25 | ((imm >> 12) & 1) << 31;
            c = (imm % 2 != 0) ? 2'd1 : (imm < -4096 || imm > 4094) ? 2'd2 : 2'd0;
         end
         4: begin
            w = op | rd << 7 | (imm & 32'hfffff000);
            c = (imm & 'hfff) != 0 ? 2'd1 : 2'd0;
         end
         5: begin
            w = op | rd << 7 | ((imm >> 12) & 255) << 12 | ((imm >> 11) & 1) << 20 | ((imm >> 1) & 1023) << 21
                | ((imm >> 20) & 1) << 31;
            c = (imm % 2 != 0) ? 2'd1 : (imm < -1048576 || imm > 1048574) ? 2'd2 : 2'd0;
         end
         default: c = 2'd3;
      endcase
   endfunction

   always @(posedge clk) begin
      logic [31:0] w;
      logic [1:0] c;
      wr_t h;
      started = 1'b1;
      if (reset) begin
         q.delete();
         m_count = 0;
         m_done = 1'b0;
         m_err = 1'b0;
         m_code = 2'd0;
      end else begin
         m_err = 1'b0;
         if (bus.req_ready && bus.req_valid) begin
            enc(bus.req_fmt, bus.req_opcode, bus.req_funct3, bus.req_funct7, bus.req_rd, bus.req_rs1,
                bus.req_rs2, bus.req_imm, w, c);
            m_code = c;
            if (c == 2'd0) q.push_back('{BASE + 32'(4 * m_count), w, bus.req_last});
            else m_err = 1'b1;
         end else if (bus.imem_wr_en && bus.imem_wr_ack && q.size() != 0) begin
            h = q.pop_front();
            m_count++;
            if (h.last || m_count == CAP) m_done = 1'b1;
         end else if (m_done && restart) begin
            m_done = 1'b0;
            m_count = 0;
         end
      end
   end

   always @(negedge clk) if (started) begin
      chk("req_ready", bus.req_ready, !(m_done || q.size() != 0 || m_err));
      chk("wr_en", bus.imem_wr_en, q.size() != 0);
      if (q.size() != 0) begin
         chk("wr_addr", bus.imem_addr, q[0].addr);
         chk("wr_data", bus.imem_wr_data, q[0].data);
      end
      chk("err", err, m_err);
      chk("err_code", err_code, m_code);
      chk("count", count, m_count);
      chk("full", full, m_count == CAP);
      chk("done", done, m_done);
      chk("addr", bus.imem_addr, BASE + 32'(4 * m_count));
   end

   task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, rs1, rs2, input logic [31:0] imm, input logic last, input int dly,
                       input logic [1:0] ec, input logic [31:0] ea, input logic [31:0] ew);
      int n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         chk("ready_timeout", bus.req_ready, 1);
         return;
      end
      bus.req_fmt = f; bus.req_opcode = op; bus.req_funct3 = f3; bus.req_funct7 = f7;
      bus.req_rd = rd; bus.req_rs1 = rs1; bus.req_rs2 = rs2; bus.req_imm = imm; bus.req_last = last;
      bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (ec != 2'd0) begin
         chk("lit_err_pulse", err, 1);
         chk("lit_err_code", err_code, ec);
         chk("lit_no_write", bus.imem_wr_en, 0);
         @(negedge clk);
      end else begin
         chk("lit_addr", bus.imem_addr, ea);
         chk("lit_data", bus.imem_wr_data, ew);
         repeat (dly) begin
            @(negedge clk);
            chk("hold_en", bus.imem_wr_en, 1);
            chk("hold_addr", bus.imem_addr, ea);
            chk("hold_data", bus.imem_wr_data, ew);
            chk("hold_ready", bus.req_ready, 0);
         end
         bus.imem_wr_ack = 1'b1;
         @(negedge clk);
         bus.imem_wr_ack = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] w;
      logic [1:0] c;
      bus.req_valid = 1'b0; bus.imem_wr_ack = 1'b0; bus.req_last = 1'b0;
      bus.req_fmt = 3'd0; bus.req_opcode = 7'd0; bus.req_funct3 = 3'd0; bus.req_funct7 = 7'd0;
      bus.req_rd = 5'd0; bus.req_rs1 = 5'd0; bus.req_rs2 = 5'd0; bus.req_imm = 32'd0;
      enc(1, 'h13, 0, 0, 1, 0, 0, 5, w, c);       chk("pin_addi", w, 32'h00500093);
      enc(3, 'h63, 0, 0, 0, 0, 0, -4, w, c);      chk("pin_beq", w, 32'hFE000EE3);
      enc(5, 'h6f, 0, 0, 1, 0, 0, 2048, w, c);    chk("pin_jal", w, 32'h001000EF);
      enc(4, 'h37, 0, 0, 5, 0, 0, 'h12345000, w, c); chk("pin_lui", w, 32'h123452B7);
      enc(3, 'h63, 0, 0, 0, 0, 0, 3, w, c);       chk("pin_b_odd", c, 2'd1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, 0, 2'd0, 32'h0, 32'h00500093);
      chk("lit_count_one", count, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 0, 2'd0, 32'h0, 32'h0020A423);
      send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4, 1'b0, 0, 2'd0, 32'h4, 32'hFE000EE3);
      send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3, 1'b0, 0, 2'd1, 32'h0, 32'h0);
      send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0, 0, 2'd2, 32'h0, 32'h0);
      send(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 1'b1, 0, 2'd3, 32'h0, 32'h0);
      send(3'd5, 7'h6f, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1048576, 1'b0, 0, 2'd2, 32'h0, 32'h0);
      send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345001, 1'b0, 0, 2'd1, 32'h0, 32'h0);
      chk("lit_count_after_err", count, 2);
      send(3'd5, 7'h6f, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b1, 3, 2'd0, 32'h8, 32'h001000EF);
      chk("lit_done", done, 1);
      bus.req_valid = 1'b1;
      bus.imem_wr_ack = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("lit_done_ready", bus.req_ready, 0);
         chk("lit_done_no_wr", bus.imem_wr_en, 0);
      end
      bus.req_valid = 1'b0;
      bus.imem_wr_ack = 1'b0;
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      chk("lit_restart_addr", bus.imem_addr, 32'h0);
      chk("lit_restart_count", count, 0);
      chk("lit_restart_done", done, 0);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0, 0, 2'd0, 32'h0, 32'h123452B7);
      send(3'd1, 7'h13, 3'd5, 7'h20, 5'd3, 5'd1, 5'd0, 32'd5, 1'b0, 0, 2'd0, 32'h4, 32'h4050D193);
      send(3'd1, 7'h13, 3'd1, 7'h00, 5'd3, 5'd1, 5'd0, 32'd32, 1'b0, 0, 2'd2, 32'h0, 32'h0);
      send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'hDEADBEEF, 1'b0, 0, 2'd0, 32'h8, 32'h002081B3);
      send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, -32'sd4, 1'b0, 0, 2'd0, 32'hC, 32'hFE000EE3);
      chk("lit_full", full, 1);
      chk("lit_done_full", done, 1);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
      bus.req_fmt = 3'd1; bus.req_opcode = 7'h13; bus.req_funct3 = 3'd0; bus.req_rd = 5'd1;
      bus.req_rs1 = 5'd0; bus.req_imm = 32'd5; bus.req_last = 1'b0;
      bus.req_valid = 1'b1;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("lit_pre_reset_wr", bus.imem_wr_en, 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("lit_rst_wr_en", bus.imem_wr_en, 0);
      chk("lit_rst_ready", bus.req_ready, 1);
      chk("lit_rst_addr", bus.imem_addr, 32'h0);
      chk("lit_rst_data", bus.imem_wr_data, 32'h0);
      chk("lit_rst_count", count, 0);
      chk("lit_rst_err_code", err_code, 0);
      chk("lit_rst_flags", {done, full, err}, 0);
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RV32I instruction encoder/loader: accepts field-level instruction requests (format, opcode, registers, functs, immediate) over a valid/ready handshake and range-checks them. Each legal request is packed into a 32-bit instruction word and written into instruction memory at consecutive word addresses. It is the write-side counterpart of the core's instruction decoder and is used by boot/self-test logic and benches to place programs in IMEM.

## Interface
- `ADDR_WIDTH`, 10: word-address width of IMEM; capacity 2**ADDR_WIDTH instructions
- `BASE_ADDR`, 32'h0: byte address of first write (must be 4-byte aligned)
- `clk` in 1: clock
- `reset` in 1: one clock; reset is synchronous and active-high
- `req_valid` in 1: request present
- `req_ready` out 1: encoder can accept a request
- `req_fmt` in 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6/7 illegal
- `req_opcode` in 7, `req_funct3` in 3, `req_funct7` in 7: placed verbatim
- `req_rd`, `req_rs1`, `req_rs2` in 5 each: register indices
- `req_imm` in 32: signed byte-valued immediate (U: full 32-bit value)
- `req_last` in 1: final instruction of program
- `restart` in 1: leave DONE, rewind address/count
- `imem_wr_en` out 1: write strobe, held until ack
- `imem_addr` out 32: byte address of write
- `imem_wr_data` out 32: encoded instruction
- `imem_wr_ack` in 1: IMEM accepted write
- `done` out 1: program complete (level)
- `full` out 1: capacity exhausted (level)
- `err` out 1: one-cycle pulse on rejected request
- `err_code` out 2: 0 none, 1 misaligned, 2 out of range, 3 bad format
- `count` out ADDR_WIDTH+1: instructions written

## Operation
- States: READY, WRITE, ERR, DONE.
- READY: `req_ready`=1. On `req_valid`&`req_ready`, capture all fields, check, then go to WRITE (legal) or ERR (illegal).
- Packing: R `{f7,rs2,rs1,f3,rd,op}`; I `{imm[11:0],rs1,f3,rd,op}`, except op=0010011 with f3 001/101 → `{f7,imm[4:0],rs1,f3,rd,op}`; S `{imm[11:5],rs2,rs1,f3,imm[4:0],op}`; B `{imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}`; U `{imm[31:12],rd,op}`; J `{imm[20],imm[10:1],imm[11],imm[19:12],rd,op}`.
- Checks (priority: format, misaligned, range): I/S imm in −2048..2047 (shift form 0..31); B imm[0]=0, −4096..4094; J imm[0]=0, −1 MiB..1 MiB−2; U imm[11:0]=0; R ignores imm.
- WRITE: `imem_wr_en`=1, addr/data stable. On ack: addr+=4, count+=1; then DONE if captured `req_last` or count reaches 2**ADDR_WIDTH (`full`=1), else READY.
- ERR: `err`=1 for one cycle, `err_code` set and held until next accepted request or reset; no write, addr/count unchanged; return to READY.
- DONE: `done`=1, `req_ready`=0. `restart` → READY, addr=BASE_ADDR, count=0, `done`/`full` cleared. `restart` ignored outside DONE.

## Timing
- Reset values: READY, `req_ready`=1, `imem_wr_en`=0, `imem_addr`=BASE_ADDR, `imem_wr_data`=0, `done`=`full`=`err`=0, `err_code`=0, `count`=0.
- Accept at cycle N → `imem_wr_en` high at N+1 (registered data).
- Ack at N+1 → `req_ready` high at N+2; peak rate one instruction per 2 cycles.
- `req_ready`=0 in WRITE, ERR, DONE; `req_valid` there is not consumed.
- `imem_wr_ack` outside WRITE ignored.
- Reset mid-WRITE aborts the write; `imem_wr_en` low the next cycle.
- `req_last` on an illegal request: ERR, then READY (not DONE).

## Structure
- Shared package `rv32i_pkg`: format enum, opcode localparams shared with the decoder, error-code constants.
- One combinational sub-module `instr_pack` (fields+fmt → word, err_code). FSM, counters and IMEM handshake stay in `instr_encoder`.

## Test plan
- I ADDI x1,x0,5 (op 0010011, f3 0, imm 5), ack immediate → write 0x00500093 @0x0, count=1.
- S SW x2,8(x1); then B BEQ x0,x0,−4 → 0x0020A423 @0x0, 0xFE000EE3 @0x4.
- J JAL x1,+2048 and U LUI x5,0x12345000 → 0x001000EF and 0x123452B7.
- B imm=3 → `err` pulse, `err_code`=1, no `imem_wr_en`, count unchanged; I imm=4096 → `err_code`=2; fmt=7 → `err_code`=3.
- Ack delayed 3 cycles → `imem_wr_en`, addr, data stable 4 cycles; `req_ready` low throughout.
- `req_last` on 3rd request → `done`=1, `req_ready`=0 until `restart`, then addr=0x0, count=0. ADDR_WIDTH=2: 4 writes → `full`=1. Reset asserted mid-WRITE → all outputs at reset values.
